// File: rtl/uart_pkg.sv
// Shared UART definitions: TX buffer drain states, default depth and byte width.
package uart_pkg;

    localparam int UART_TXBUF_DEPTH_DEFAULT = 16;
    localparam int UART_BYTE_W              = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_SENDING
    } tx_buf_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte storage for the TX buffer: circular memory, pointers, occupancy count and flush.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_TXBUF_DEPTH_DEFAULT,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [UART_BYTE_W-1:0] wr_data_i,
    output logic [UART_BYTE_W-1:0] rd_data_o,
    output logic [CW-1:0]          count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    logic [UART_BYTE_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   do_push, do_pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Flush cancels any push or pop in the same cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit FIFO between the TX-data register path and the serializer, with drain FSM and status flags.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter  int DEPTH  = UART_TXBUF_DEPTH_DEFAULT,
    parameter  int LOW_WM = 4,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    input  logic [UART_BYTE_W-1:0] wr_data,
    output logic                   wr_ready,
    input  logic                   flush,
    input  logic                   tx_en,
    output logic [UART_BYTE_W-1:0] ser_data,
    output logic                   ser_start,
    input  logic                   ser_busy,
    input  logic                   ser_done,
    output logic [CW-1:0]          count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic                   low_wm,
    output logic                   idle
);

    tx_buf_state_t          state_q, state_d;
    logic [UART_BYTE_W-1:0] ser_data_q, ser_data_d;
    logic                   ser_start_q, ser_start_d;
    logic                   overflow_q, overflow_d;
    logic                   low_wm_q, low_wm_d;
    logic                   pop;
    logic [UART_BYTE_W-1:0] fifo_rd_data;

    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (wr_valid),
        .pop_i     (pop),
        .flush_i   (flush),
        .wr_data_i (wr_data),
        .rd_data_o (fifo_rd_data),
        .count_o   (count),
        .empty_o   (empty),
        .full_o    (full)
    );

    assign wr_ready  = !full;
    assign ser_data  = ser_data_q;
    assign ser_start = ser_start_q;
    assign overflow  = overflow_q;
    assign low_wm    = low_wm_q;
    assign idle      = empty && (state_q == S_IDLE);

    // A launch is held off during flush so the popped byte and the count stay consistent.
    always_comb begin
        state_d     = state_q;
        ser_start_d = 1'b0;
        ser_data_d  = ser_data_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_en && !empty && !ser_busy && !flush) begin
                    state_d     = S_WAIT_BUSY;
                    ser_start_d = 1'b1;
                    ser_data_d  = fifo_rd_data;
                    pop         = 1'b1;
                end
            end
            S_WAIT_BUSY: if (ser_busy) state_d = S_SENDING;
            S_SENDING:   if (ser_done) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        overflow_d = overflow_q;
        if (wr_valid && full && !flush) overflow_d = 1'b1;
        else if (ovf_clr)               overflow_d = 1'b0;

        low_wm_d = (count <= CW'(LOW_WM));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ser_data_q  <= '0;
            ser_start_q <= 1'b0;
            overflow_q  <= 1'b0;
            low_wm_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            ser_data_q  <= ser_data_d;
            ser_start_q <= ser_start_d;
            overflow_q  <= overflow_d;
            low_wm_q    <= low_wm_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed testbench for uart_tx_buffer with a small serializer model that logs launched bytes.
module tb_uart_tx_buffer;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       flush;
    logic       tx_en;
    logic [7:0] ser_data;
    logic       ser_start;
    logic       ser_busy;
    logic       ser_done;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       ovf_clr;
    logic       low_wm;
    logic       idle;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] sent [$];
    int         busyCnt;

    uart_tx_buffer #(.DEPTH(16), .LOW_WM(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .flush     (flush),
        .tx_en     (tx_en),
        .ser_data  (ser_data),
        .ser_start (ser_start),
        .ser_busy  (ser_busy),
        .ser_done  (ser_done),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .low_wm    (low_wm),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serializer model: busy one cycle after ser_start, busy for 4 cycles, then a done pulse.
    always @(posedge clk) begin
        if (rst) begin
            ser_busy <= 1'b0;
            ser_done <= 1'b0;
            busyCnt  <= 0;
        end else begin
            ser_done <= 1'b0;
            if (ser_start) begin
                ser_busy <= 1'b1;
                busyCnt  <= 3;
                sent.push_back(ser_data);
            end else if (ser_busy) begin
                if (busyCnt == 0) begin
                    ser_busy <= 1'b0;
                    ser_done <= 1'b1;
                end else begin
                    busyCnt <= busyCnt - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int n = 0;
        while (!idle && n < limit) begin
            tick();
            n++;
        end
        ok = idle;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_fifo: count=%0d empty=%b full=%b wr_ready=%b, required 0 1 0 1",
                     count, empty, full, wr_ready);
        end
        checks++;
        if (overflow !== 1'b0 || low_wm !== 1'b1 || idle !== 1'b1 || ser_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: overflow=%b low_wm=%b idle=%b ser_start=%b, required 0 1 1 0",
                     overflow, low_wm, idle, ser_start);
        end
    endtask

    task automatic test_single();
        bit ok;
        sent.delete();
        tx_en = 1'b1;
        write_byte(8'h55);
        checks++;
        if (count !== 5'd1 || ser_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_accept: count=%0d ser_start=%b, required 1 0", count, ser_start);
        end
        tick();
        checks++;
        if (ser_start !== 1'b1 || ser_data !== 8'h55 || count !== 5'd0 || idle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_launch: ser_start=%b ser_data=%h count=%0d idle=%b, required 1 55 0 0",
                     ser_start, ser_data, count, idle);
        end
        tick();
        checks++;
        if (ser_start !== 1'b0 || ser_data !== 8'h55) begin
            errors++;
            $display("[TB] FAIL single_pulse: ser_start=%b ser_data=%h, required 0 55", ser_start, ser_data);
        end
        wait_idle(50, ok);
        checks++;
        if (!ok || sent.size() != 1 || sent[0] !== 8'h55) begin
            errors++;
            $display("[TB] FAIL single_done: idle=%b sent=%0d, required idle=1 sent=1 byte 55", idle, sent.size());
        end
    endtask

    task automatic test_fill_overflow();
        bit ok;
        sent.delete();
        tx_en = 1'b0;
        for (int i = 0; i < 16; i++) write_byte(8'h41 + 8'(i));
        checks++;
        if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 5'd16) begin
            errors++;
            $display("[TB] FAIL fill_full: full=%b wr_ready=%b count=%0d, required 1 0 16", full, wr_ready, count);
        end
        ovf_clr = 1'b1;
        write_byte(8'h99);
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("[TB] FAIL fill_overflow: overflow=%b count=%0d, required 1 16", overflow, count);
        end
        tx_en = 1'b1;
        wait_idle(400, ok);
        checks++;
        if (!ok || sent.size() != 16) begin
            errors++;
            $display("[TB] FAIL fill_drain: idle=%b sent=%0d, required 1 16", idle, sent.size());
        end
        for (int i = 0; i < 16 && i < sent.size(); i++) begin
            checks++;
            if (sent[i] !== 8'h41 + 8'(i)) begin
                errors++;
                $display("[TB] FAIL fill_order[%0d]: got %h, required %h", i, sent[i], 8'h41 + 8'(i));
            end
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clear: overflow=%b, required 0", overflow);
        end
    endtask

    task automatic test_push_pop_full();
        bit ok;
        tx_en = 1'b0;
        for (int i = 0; i < 16; i++) write_byte(8'h10 + 8'(i));
        tx_en = 1'b1;
        write_byte(8'hEE);
        checks++;
        if (count !== 5'd15 || overflow !== 1'b1 || ser_start !== 1'b1 || ser_data !== 8'h10) begin
            errors++;
            $display("[TB] FAIL push_pop_full: count=%0d overflow=%b ser_start=%b ser_data=%h, required 15 1 1 10",
                     count, overflow, ser_start, ser_data);
        end
        tx_en = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle(50, ok);
        checks++;
        if (!ok || count !== 5'd0) begin
            errors++;
            $display("[TB] FAIL push_pop_cleanup: idle=%b count=%0d, required 1 0", idle, count);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    task automatic test_flush();
        bit ok;
        sent.delete();
        tx_en = 1'b0;
        for (int i = 0; i < 5; i++) write_byte(8'h61 + 8'(i));
        tx_en = 1'b1;
        tick();
        checks++;
        if (ser_start !== 1'b1 || ser_data !== 8'h61 || count !== 5'd4) begin
            errors++;
            $display("[TB] FAIL flush_launch: ser_start=%b ser_data=%h count=%0d, required 1 61 4",
                     ser_start, ser_data, count);
        end
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_state: count=%0d empty=%b overflow=%b, required 0 1 0", count, empty, overflow);
        end
        wait_idle(50, ok);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (!ok || sent.size() != 1 || sent[0] !== 8'h61) begin
            errors++;
            $display("[TB] FAIL flush_inflight: idle=%b sent=%0d, required idle=1 and only byte 61", idle, sent.size());
        end
    endtask

    task automatic test_low_wm();
        bit ok;
        int n = 0;
        tx_en = 1'b0;
        for (int i = 0; i < 6; i++) write_byte(8'hA0 + 8'(i));
        tick();
        checks++;
        if (low_wm !== 1'b0 || count !== 5'd6) begin
            errors++;
            $display("[TB] FAIL lowwm_high_count: low_wm=%b count=%0d, required 0 6", low_wm, count);
        end
        tx_en = 1'b1;
        while (count !== 5'd4 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (count !== 5'd4 || low_wm !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lowwm_at_edge: count=%0d low_wm=%b, required 4 0", count, low_wm);
        end
        tick();
        checks++;
        if (low_wm !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lowwm_rise: low_wm=%b, required 1", low_wm);
        end
        wait_idle(200, ok);
        checks++;
        if (!ok || count !== 5'd0) begin
            errors++;
            $display("[TB] FAIL lowwm_drain: idle=%b count=%0d, required 1 0", idle, count);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        int sz;
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) write_byte(8'h31 + 8'(i));
        tx_en = 1'b1;
        tick();
        while (ser_busy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || idle !== 1'b1 || ser_start !== 1'b0 ||
            ser_data !== 8'h00 || overflow !== 1'b0 || low_wm !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid: count=%0d empty=%b idle=%b start=%b data=%h ovf=%b lowwm=%b, required 0 1 1 0 00 0 1",
                     count, empty, idle, ser_start, ser_data, overflow, low_wm);
        end
        sz = sent.size();
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (sent.size() != sz) begin
            errors++;
            $display("[TB] FAIL reset_no_launch: launches=%0d, required 0", sent.size() - sz);
        end
        write_byte(8'h5A);
        tick();
        checks++;
        if (ser_start !== 1'b1 || ser_data !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL reset_relaunch: ser_start=%b ser_data=%h, required 1 5a", ser_start, ser_data);
        end
        wait_idle(50, ok);
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        flush    = 1'b0;
        tx_en    = 1'b0;
        ovf_clr  = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_push_pop_full();
        test_flush();
        test_low_wm();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
